mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data RAM/controller (slave).
// The request fields are held constant by the master until the slave acks.
interface mem_access_stage_if;
  logic        odmem_req;
  logic        odmem_we;
  logic [31:0] odmem_addr;
  logic [31:0] odmem_wdata;
  logic [3:0]  odmem_be;
  logic        idmem_ack;
  logic [31:0] idmem_rdata;

  modport master (
    output odmem_req, odmem_we, odmem_addr, odmem_wdata, odmem_be,
    input  idmem_ack, idmem_rdata
  );

  modport slave (
    input  odmem_req, odmem_we, odmem_addr, odmem_wdata, odmem_be,
    output idmem_ack, idmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory access per instruction, stalls the
// upstream stage until ack or timeout, and fills the MEM/WB register.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ivalid,
  input  logic                 iSig_MemRead,
  input  logic                 iSig_MemWrite,
  input  logic                 iSig_regfile_write,
  input  logic                 iSig_MemtoReg,
  input  logic [31:0]          ialu_result,
  input  logic [31:0]          istore_data,
  input  logic [1:0]           imem_size,
  input  logic                 imem_unsigned,
  input  logic [4:0]           iwrite_reg,
  output logic                 ostall,
  mem_access_stage_if.master   dmem,
  output logic                 ovalid,
  output logic                 oSig_regfile_write,
  output logic                 oSig_MemtoReg,
  output logic                 omisalign,
  output logic                 obus_error,
  output logic [31:0]          oread_from_ram,
  output logic [31:0]          oalu_result,
  output logic [4:0]           owrite_reg
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        valid_q, valid_d;
  logic        regw_q, regw_d;
  logic        m2r_q, m2r_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  wreg_q, wreg_d;

  logic        memop, misaligned, size_half, size_word;
  logic        stall_c;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;

  // Lane steering for stores and lane extraction for loads (little-endian).
  always_comb begin
    size_half = (imem_size == 2'b01);
    size_word = imem_size[1];
    memop      = ivalid & (iSig_MemRead | iSig_MemWrite);
    misaligned = (size_half & ialu_result[0]) | (size_word & (ialu_result[1:0] != 2'b00));

    lane_be    = 4'b1111;
    lane_wdata = istore_data;
    if (imem_size == 2'b00) begin
      lane_be    = 4'b0001 << ialu_result[1:0];
      lane_wdata = {4{istore_data[7:0]}};
    end else if (size_half) begin
      lane_be    = ialu_result[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{istore_data[15:0]}};
    end

    case (ialu_result[1:0])
      2'b00:   load_byte = dmem.idmem_rdata[7:0];
      2'b01:   load_byte = dmem.idmem_rdata[15:8];
      2'b10:   load_byte = dmem.idmem_rdata[23:16];
      default: load_byte = dmem.idmem_rdata[31:24];
    endcase
    load_half = ialu_result[1] ? dmem.idmem_rdata[31:16] : dmem.idmem_rdata[15:0];

    load_val = dmem.idmem_rdata;
    if (imem_size == 2'b00)
      load_val = imem_unsigned ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
    else if (size_half)
      load_val = imem_unsigned ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
  end

  // Next-state, bus request and MEM/WB register contents; a bubble is the default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    valid_d = 1'b0;
    regw_d  = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    m2r_d   = m2r_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    stall_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ivalid) begin
          if (!memop || misaligned) begin
            valid_d = 1'b1;
            regw_d  = memop ? 1'b0 : iSig_regfile_write;
            mis_d   = memop;
            m2r_d   = iSig_MemtoReg;
            rdata_d = 32'h0;
            alu_d   = ialu_result;
            wreg_d  = iwrite_reg;
          end else begin
            stall_c = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 8'h0;
            req_d   = 1'b1;
            we_d    = iSig_MemWrite;
            addr_d  = {ialu_result[31:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_wdata;
          end
        end
      end
      S_WAIT: begin
        stall_c = !dmem.idmem_ack;
        if (dmem.idmem_ack || cnt_q == TIMEOUT_LAST) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          berr_d  = !dmem.idmem_ack;
          regw_d  = dmem.idmem_ack & iSig_regfile_write;
          m2r_d   = iSig_MemtoReg;
          rdata_d = (dmem.idmem_ack && !we_q) ? load_val : 32'h0;
          alu_d   = ialu_result;
          wreg_d  = iwrite_reg;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      valid_q <= 1'b0;
      regw_q  <= 1'b0;
      m2r_q   <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= 32'h0;
      alu_q   <= 32'h0;
      wreg_q  <= 5'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      regw_q  <= regw_d;
      m2r_q   <= m2r_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
    end
  end

  assign ostall             = stall_c & !rstn;
  assign dmem.odmem_req     = req_q;
  assign dmem.odmem_we      = we_q;
  assign dmem.odmem_addr    = addr_q;
  assign dmem.odmem_wdata   = wdata_q;
  assign dmem.odmem_be      = be_q;
  assign ovalid             = valid_q;
  assign oSig_regfile_write = regw_q;
  assign oSig_MemtoReg      = m2r_q;
  assign omisalign          = mis_q;
  assign obus_error         = berr_q;
  assign oread_from_ram     = rdata_q;
  assign oalu_result        = alu_q;
  assign owrite_reg         = wreg_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a table of single-instruction vectors
// plus hand-written reset/idle sequences, all with hand-computed expectations.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ivalid, rd, wr, regw, m2r, uns;
  logic [1:0]  size;
  logic [31:0] alu, sdata;
  logic [4:0]  wreg;
  logic        ostall, ovalid, oregw, om2r, omis, oberr;
  logic [31:0] oread, oalu;
  logic [4:0]  owreg;
  int          total = 0;
  int          bad = 0;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .ivalid(ivalid),
    .iSig_MemRead(rd), .iSig_MemWrite(wr),
    .iSig_regfile_write(regw), .iSig_MemtoReg(m2r),
    .ialu_result(alu), .istore_data(sdata),
    .imem_size(size), .imem_unsigned(uns), .iwrite_reg(wreg),
    .ostall(ostall), .dmem(bus),
    .ovalid(ovalid), .oSig_regfile_write(oregw), .oSig_MemtoReg(om2r),
    .omisalign(omis), .obus_error(oberr),
    .oread_from_ram(oread), .oalu_result(oalu), .owrite_reg(owreg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, regw, m2r, uns;
    logic [1:0]  size;
    logic [31:0] addr, sdata;
    logic [4:0]  wreg;
    int          ack_delay;
    logic [31:0] rdata;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rdata;
    logic        exp_mis, exp_berr, exp_regw;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, w, rw, mr, u, input logic [1:0] sz,
                         input logic [31:0] a, sd, input logic [4:0] wrg,
                         input int dly, input logic [31:0] rdt, input logic ereq,
                         input logic [3:0] ebe, input logic [31:0] ewd, erd,
                         input logic emis, eberr, erw);
    vec_t v;
    v.rd = r; v.wr = w; v.regw = rw; v.m2r = mr; v.uns = u; v.size = sz;
    v.addr = a; v.sdata = sd; v.wreg = wrg; v.ack_delay = dly; v.rdata = rdt;
    v.exp_req = ereq; v.exp_be = ebe; v.exp_wdata = ewd; v.exp_rdata = erd;
    v.exp_mis = emis; v.exp_berr = eberr; v.exp_regw = erw;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    ivalid = 0; rd = 0; wr = 0; regw = 0; m2r = 0; uns = 0;
    size = 2'b00; alu = 32'h0; sdata = 32'h0; wreg = 5'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    string t;
    bit acked;
    t = $sformatf("v%0d", idx);
    ivalid = 1; rd = v.rd; wr = v.wr; regw = v.regw; m2r = v.m2r; uns = v.uns;
    size = v.size; alu = v.addr; sdata = v.sdata; wreg = v.wreg;
    #1;
    check_output({t, ".stall_idle"}, 32'(ostall), 32'(v.exp_req));
    tick();
    acked = 0;
    if (v.exp_req) begin
      for (int k = 0; k < TO; k++) begin
        check_output($sformatf("%s.req%0d", t, k), 32'(bus.odmem_req), 32'h1);
        check_output($sformatf("%s.addr%0d", t, k), bus.odmem_addr, {v.addr[31:2], 2'b00});
        check_output($sformatf("%s.we%0d", t, k), 32'(bus.odmem_we), 32'(v.wr));
        if (v.wr) begin
          check_output($sformatf("%s.be%0d", t, k), 32'(bus.odmem_be), 32'(v.exp_be));
          check_output($sformatf("%s.wdata%0d", t, k), bus.odmem_wdata, v.exp_wdata);
        end
        if (k == 0) check_output({t, ".valid_wait"}, 32'(ovalid), 32'h0);
        if (k == v.ack_delay) begin
          bus.idmem_ack = 1;
          bus.idmem_rdata = v.rdata;
        end
        #1;
        check_output($sformatf("%s.stall%0d", t, k), 32'(ostall), 32'(!bus.idmem_ack));
        tick();
        if (bus.idmem_ack) begin
          acked = 1;
          bus.idmem_ack = 0;
          break;
        end
      end
      check_output({t, ".acked"}, 32'(acked), 32'(!v.exp_berr));
    end
    check_output({t, ".valid"}, 32'(ovalid), 32'h1);
    check_output({t, ".req_done"}, 32'(bus.odmem_req), 32'h0);
    check_output({t, ".regw"}, 32'(oregw), 32'(v.exp_regw));
    check_output({t, ".mis"}, 32'(omis), 32'(v.exp_mis));
    check_output({t, ".berr"}, 32'(oberr), 32'(v.exp_berr));
    check_output({t, ".rdata"}, oread, v.exp_rdata);
    check_output({t, ".alu"}, oalu, v.addr);
    check_output({t, ".wreg"}, 32'(owreg), 32'(v.wreg));
    check_output({t, ".m2r"}, 32'(om2r), 32'(v.m2r));
    clear_inputs();
    tick();
    check_output({t, ".bubble_valid"}, 32'(ovalid), 32'h0);
    check_output({t, ".bubble_flags"}, {30'h0, omis, oberr}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    bus.idmem_ack = 0;
    bus.idmem_rdata = 32'h0;
    rstn = 1;

    //             rd wr rw m2 u  sz     addr          sdata         wr  dly rdata         req be       wdata         rdata_out     mis berr regw
    add_vec(0, 0, 1, 0, 0, 2'b00, 32'h0000_1234, 32'h0,        5'd5,  0, 32'h0,        0, 4'h0,    32'h0,        32'h0,        0, 0, 1);
    add_vec(1, 0, 1, 1, 0, 2'b00, 32'h0000_0103, 32'h0,        5'd6,  0, 32'h80AABBCC, 1, 4'h0,    32'h0,        32'hFFFFFF80, 0, 0, 1);
    add_vec(1, 0, 1, 1, 1, 2'b00, 32'h0000_0103, 32'h0,        5'd7,  0, 32'h80AABBCC, 1, 4'h0,    32'h0,        32'h00000080, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 2'b01, 32'h0000_0102, 32'h0000BEEF, 5'd0,  3, 32'h0,        1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 0);
    add_vec(1, 0, 1, 1, 0, 2'b10, 32'h0000_0101, 32'h0,        5'd8,  0, 32'h0,        0, 4'h0,    32'h0,        32'h0,        1, 0, 0);
    add_vec(1, 0, 1, 1, 0, 2'b01, 32'h0000_0102, 32'h0,        5'd9,  1, 32'h80011234, 1, 4'h0,    32'h0,        32'hFFFF8001, 0, 0, 1);
    add_vec(1, 0, 1, 1, 1, 2'b01, 32'h0000_0100, 32'h0,        5'd10, 0, 32'h1234F00D, 1, 4'h0,    32'h0,        32'h0000F00D, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 2'b00, 32'h0000_0201, 32'h123456A5, 5'd0,  0, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 2'b10, 32'h0000_0204, 32'hDEADBEEF, 5'd0,  1, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    add_vec(1, 0, 1, 1, 0, 2'b11, 32'h0000_0108, 32'h0,        5'd11, 2, 32'hCAFEBABE, 1, 4'h0,    32'h0,        32'hCAFEBABE, 0, 0, 1);
    add_vec(0, 1, 0, 0, 0, 2'b01, 32'h0000_0103, 32'h0000BEEF, 5'd0,  0, 32'h0,        0, 4'h0,    32'h0,        32'h0,        1, 0, 0);
    add_vec(1, 0, 1, 1, 0, 2'b10, 32'h0000_0400, 32'h0,        5'd12, -1, 32'h0,       1, 4'h0,    32'h0,        32'h0,        0, 1, 0);
    add_vec(1, 1, 0, 0, 0, 2'b10, 32'h0000_0010, 32'h11223344, 5'd0,  0, 32'h55555555, 1, 4'b1111, 32'h11223344, 32'h0,      0, 0, 0);
    add_vec(1, 0, 1, 1, 0, 2'b00, 32'h0000_0101, 32'h0,        5'd13, 0, 32'h00007F00, 1, 4'h0,    32'h0,        32'h0000007F, 0, 0, 1);

    tick();
    tick();
    check_output("rst.valid", 32'(ovalid), 32'h0);
    check_output("rst.req", 32'(bus.odmem_req), 32'h0);
    check_output("rst.addr", bus.odmem_addr, 32'h0);
    check_output("rst.rdata", oread, 32'h0);
    ivalid = 1; rd = 1;
    #1;
    check_output("rst.stall", 32'(ostall), 32'h0);
    clear_inputs();
    rstn = 0;
    tick();

    foreach (vecs[i]) apply_stimulus(i, vecs[i]);

    // Memory control without ivalid, and a stray ack while idle, must do nothing.
    rd = 1; size = 2'b10; alu = 32'h0000_0020;
    bus.idmem_ack = 1;
    #1;
    check_output("idle.stall", 32'(ostall), 32'h0);
    tick();
    check_output("idle.req", 32'(bus.odmem_req), 32'h0);
    check_output("idle.valid", 32'(ovalid), 32'h0);
    bus.idmem_ack = 0;
    clear_inputs();

    // Reset in the second WAIT cycle abandons the access; a later ack is ignored.
    ivalid = 1; rd = 1; regw = 1; size = 2'b10; alu = 32'h0000_0300; wreg = 5'd3;
    tick();
    tick();
    check_output("rw.req_before", 32'(bus.odmem_req), 32'h1);
    rstn = 1;
    clear_inputs();
    #1;
    check_output("rw.stall_in_reset", 32'(ostall), 32'h0);
    tick();
    check_output("rw.req", 32'(bus.odmem_req), 32'h0);
    check_output("rw.addr", bus.odmem_addr, 32'h0);
    check_output("rw.be", 32'(bus.odmem_be), 32'h0);
    check_output("rw.alu", oalu, 32'h0);
    check_output("rw.wreg", 32'(owreg), 32'h0);
    check_output("rw.valid", 32'(ovalid), 32'h0);
    rstn = 0;
    bus.idmem_ack = 1;
    bus.idmem_rdata = 32'hFFFF_FFFF;
    tick();
    check_output("rw.late_ack_valid", 32'(ovalid), 32'h0);
    check_output("rw.late_ack_rdata", oread, 32'h0);
    bus.idmem_ack = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
